// File: rtl/d16_wb_arbiter.sv
// d16_wb_arbiter: two-master / one-slave Wishbone arbiter for the d16 bus.
// Round-robin grant at transfer boundaries, combinational forwarding to the
// owner, and a wait-state watchdog that aborts unacknowledged transfers.
module d16_wb_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // master 0 (d16 core)
  input  logic        i_m0_cyc,
  input  logic        i_m0_we,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  output logic [15:0] o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  // master 1 (DMA / debug loader)
  input  logic        i_m1_cyc,
  input  logic        i_m1_we,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  output logic [15:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  // slave
  output logic        o_s_cyc,
  output logic        o_s_we,
  output logic [15:0] o_s_addr,
  output logic [15:0] o_s_dat,
  input  logic [15:0] i_s_dat,
  input  logic        i_s_ack,
  // current owner, one-hot
  output logic [1:0]  o_grant
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS0 = 2'b01,
    BUS1 = 2'b10
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       own_cyc;
  logic       tmo;

  // Owner still requesting, and watchdog expiry (an ack in the same cycle wins).
  assign own_cyc = ((state == BUS0) & i_m0_cyc) | ((state == BUS1) & i_m1_cyc);
  assign tmo     = own_cyc & ~i_s_ack & (wcnt == WCNT_LAST);

  assign o_grant = state;

  // State, last-owner and wait-counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= 1'b1;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Arbitration and transfer-boundary transitions.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    wcnt_nxt  = wcnt;
    unique case (state)
      IDLE: begin
        wcnt_nxt = '0;
        if (i_m0_cyc && (!i_m1_cyc || last)) begin
          state_nxt = BUS0;
          last_nxt  = 1'b0;
        end else if (i_m1_cyc) begin
          state_nxt = BUS1;
          last_nxt  = 1'b1;
        end
      end
      BUS0: begin
        if (!i_m0_cyc) begin
          wcnt_nxt = '0;
          if (i_m1_cyc) begin
            state_nxt = BUS1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (i_s_ack) begin
          wcnt_nxt = '0;
          if (i_m1_cyc) begin
            state_nxt = BUS1;
            last_nxt  = 1'b1;
          end
        end else if (wcnt == WCNT_LAST) begin
          wcnt_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      BUS1: begin
        if (!i_m1_cyc) begin
          wcnt_nxt = '0;
          if (i_m0_cyc) begin
            state_nxt = BUS0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (i_s_ack) begin
          wcnt_nxt = '0;
          if (i_m0_cyc) begin
            state_nxt = BUS0;
            last_nxt  = 1'b0;
          end
        end else if (wcnt == WCNT_LAST) begin
          wcnt_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Forward the owner's request to the slave and the slave's response back.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = '0;
    o_s_dat  = '0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    unique case (state)
      BUS0: begin
        o_s_cyc  = i_m0_cyc & ~tmo;
        o_s_we   = i_m0_we;
        o_s_addr = i_m0_addr;
        o_s_dat  = i_m0_dat;
        o_m0_dat = i_s_dat;
        o_m0_ack = i_s_ack & i_m0_cyc;
        o_m0_err = tmo;
      end
      BUS1: begin
        o_s_cyc  = i_m1_cyc & ~tmo;
        o_s_we   = i_m1_we;
        o_s_addr = i_m1_addr;
        o_s_dat  = i_m1_dat;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack & i_m1_cyc;
        o_m1_err = tmo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_d16_wb_arbiter.sv
// Directed testbench for d16_wb_arbiter (TIMEOUT=4).
module tb_d16_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_cyc, i_m0_we, i_m1_cyc, i_m1_we;
  logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat;
  logic [15:0] o_m0_dat, o_m1_dat;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic        o_s_cyc, o_s_we;
  logic [15:0] o_s_addr, o_s_dat;
  logic [15:0] i_s_dat;
  logic        i_s_ack;
  logic [1:0]  o_grant;

  int passed = 0;
  int total  = 0;
  int acks0  = 0;
  int acks1  = 0;

  d16_wb_arbiter #(.TIMEOUT(4)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_m0_cyc  (i_m0_cyc),
    .i_m0_we   (i_m0_we),
    .i_m0_addr (i_m0_addr),
    .i_m0_dat  (i_m0_dat),
    .o_m0_dat  (o_m0_dat),
    .o_m0_ack  (o_m0_ack),
    .o_m0_err  (o_m0_err),
    .i_m1_cyc  (i_m1_cyc),
    .i_m1_we   (i_m1_we),
    .i_m1_addr (i_m1_addr),
    .i_m1_dat  (i_m1_dat),
    .o_m1_dat  (o_m1_dat),
    .o_m1_ack  (o_m1_ack),
    .o_m1_err  (o_m1_err),
    .o_s_cyc   (o_s_cyc),
    .o_s_we    (o_s_we),
    .o_s_addr  (o_s_addr),
    .o_s_dat   (o_s_dat),
    .i_s_dat   (i_s_dat),
    .i_s_ack   (i_s_ack),
    .o_grant   (o_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  initial begin
    i_reset   = 1'b0;
    i_m0_cyc  = 1'b1;
    i_m0_we   = 1'b1;
    i_m0_addr = 16'h1234;
    i_m0_dat  = 16'h7777;
    i_m1_cyc  = 1'b0;
    i_m1_we   = 1'b0;
    i_m1_addr = 16'hABCD;
    i_m1_dat  = 16'h3333;
    i_s_dat   = 16'hBEEF;
    i_s_ack   = 1'b1;

    // reset asserted mid-clock; everything quiet before any edge
    #2 i_reset = 1'b1;
    #1;
    chk("rst_grant", 16'(o_grant), 16'h0);
    chk("rst_s_cyc", 16'(o_s_cyc), 16'h0);
    chk("rst_s_we", 16'(o_s_we), 16'h0);
    chk("rst_s_addr", o_s_addr, 16'h0);
    chk("rst_s_dat", o_s_dat, 16'h0);
    chk("rst_acks_errs", {12'h0, o_m1_err, o_m1_ack, o_m0_err, o_m0_ack}, 16'h0);
    chk("rst_m0_dat", o_m0_dat, 16'h0);
    chk("rst_m1_dat", o_m1_dat, 16'h0);

    // release, both request together: m0 wins the first tie
    #9;
    i_reset  = 1'b0;
    i_m0_we  = 1'b0;
    i_m1_cyc = 1'b1;
    i_s_ack  = 1'b0;

    // round-robin under load, slave acks every cycle
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      i_s_ack = 1'b1;
      i_s_dat = 16'h5A5A;
      mid();
      if (o_m0_ack) acks0++;
      if (o_m1_ack) acks1++;
      if (i % 2 == 0) begin
        chk("rr_grant_m0", 16'(o_grant), 16'h1);
        chk("rr_acks_m0", {14'h0, o_m1_ack, o_m0_ack}, 16'h1);
        chk("rr_addr_m0", o_s_addr, 16'h1234);
      end else begin
        chk("rr_grant_m1", 16'(o_grant), 16'h2);
        chk("rr_acks_m1", {14'h0, o_m1_ack, o_m0_ack}, 16'h2);
        chk("rr_addr_m1", o_s_addr, 16'hABCD);
      end
      if (i == 0) begin
        chk("rr_m0_rdata", o_m0_dat, 16'h5A5A);
        chk("rr_s_cyc", 16'(o_s_cyc), 16'h1);
      end
    end
    chk("rr_count_m0", 16'(acks0), 16'd5);
    chk("rr_count_m1", 16'(acks1), 16'd5);

    // sole-master streaming writes
    next_cycle();
    i_m1_cyc = 1'b0;
    i_m0_we  = 1'b1;
    i_m0_dat = 16'h00FF;
    for (int j = 0; j < 4; j++) begin
      mid();
      chk("st_ack", {15'h0, o_m0_ack}, 16'h1);
      chk("st_grant", 16'(o_grant), 16'h1);
      chk("st_we", 16'(o_s_we), 16'h1);
      chk("st_dat", o_s_dat, 16'h00FF);
      if (j < 3) next_cycle();
    end

    // m0 releases the bus
    next_cycle();
    i_m0_cyc = 1'b0;
    i_m0_we  = 1'b0;
    i_s_ack  = 1'b0;
    mid();
    chk("drop_s_cyc", 16'(o_s_cyc), 16'h0);
    chk("drop_ack", 16'(o_m0_ack), 16'h0);
    next_cycle();
    i_m1_cyc = 1'b1;
    mid();
    chk("idle_grant", 16'(o_grant), 16'h0);
    chk("idle_s_cyc", 16'(o_s_cyc), 16'h0);

    // watchdog: no ack, error in the 4th grant cycle
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      mid();
      chk("to_err", 16'(o_m1_err), (k == 4) ? 16'h1 : 16'h0);
      chk("to_s_cyc", 16'(o_s_cyc), (k == 4) ? 16'h0 : 16'h1);
      chk("to_ack", 16'(o_m1_ack), 16'h0);
    end
    next_cycle();
    i_m1_cyc = 1'b0;
    mid();
    chk("to_idle_after", 16'(o_grant), 16'h0);

    // ack arriving in the 4th cycle beats the watchdog
    next_cycle();
    i_m1_cyc = 1'b1;
    mid();
    chk("ta_idle", 16'(o_grant), 16'h0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 4) i_s_ack = 1'b1;
      mid();
      chk("ta_err", 16'(o_m1_err), 16'h0);
    end
    chk("ta_ack", 16'(o_m1_ack), 16'h1);
    chk("ta_s_cyc", 16'(o_s_cyc), 16'h1);
    next_cycle();
    i_m1_cyc = 1'b0;
    i_s_ack  = 1'b0;
    mid();
    chk("ta_stay_grant", 16'(o_grant), 16'h2);
    chk("ta_no_err", 16'(o_m1_err), 16'h0);

    // early drop by m0 hands over to m1 with no idle cycle
    next_cycle();
    i_m0_cyc = 1'b1;
    mid();
    chk("ed_idle", 16'(o_grant), 16'h0);
    next_cycle();
    i_m1_cyc = 1'b1;
    mid();
    chk("ed_grant_m0", 16'(o_grant), 16'h1);
    chk("ed_addr_m0", o_s_addr, 16'h1234);
    next_cycle();
    i_m0_cyc = 1'b0;
    mid();
    chk("ed_drop_s_cyc", 16'(o_s_cyc), 16'h0);
    next_cycle();
    mid();
    chk("ed_grant_m1", 16'(o_grant), 16'h2);
    chk("ed_s_cyc_m1", 16'(o_s_cyc), 16'h1);
    chk("ed_addr_m1", o_s_addr, 16'hABCD);
    next_cycle();
    mid();
    chk("ed_err_c2", 16'(o_m1_err), 16'h0);
    next_cycle();
    mid();
    chk("ed_err_c3", 16'(o_m1_err), 16'h0);

    // asynchronous reset while m1 owns the bus
    #2;
    i_reset = 1'b1;
    i_s_ack = 1'b1;
    #1;
    chk("mr_s_cyc", 16'(o_s_cyc), 16'h0);
    chk("mr_grant", 16'(o_grant), 16'h0);
    chk("mr_ack_err", {14'h0, o_m1_err, o_m1_ack}, 16'h0);
    chk("mr_m1_dat", o_m1_dat, 16'h0);
    i_m0_cyc = 1'b1;
    i_s_ack  = 1'b0;
    next_cycle();
    mid();
    chk("mr_hold_grant", 16'(o_grant), 16'h0);
    #2 i_reset = 1'b0;
    next_cycle();
    mid();
    chk("mr_tie_m0", 16'(o_grant), 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
